// File: rtl/mfb_checksum_inserter.sv
// mfb_checksum_inserter: writes per-packet MVB checksums (RX_MVB_*) into MFB packets (RX_MFB_* -> TX_MFB_*) at a SOF-relative byte offset
module mfb_checksum_inserter #(
  parameter int MFB_REGION_SIZE = 8,
  parameter int MFB_BLOCK_SIZE  = 8,
  parameter int MFB_ITEM_WIDTH  = 8,
  parameter int MFB_META_WIDTH  = 8,
  parameter int OFFSET_WIDTH    = 9,
  parameter     DEVICE          = "AGILEX"
) (
  input  logic                                                    CLK,
  input  logic                                                    RESET,
  input  logic [MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH-1:0] RX_MFB_DATA,
  input  logic [MFB_META_WIDTH-1:0]                               RX_MFB_META,
  input  logic [OFFSET_WIDTH-1:0]                                 RX_MFB_OFFSET,
  input  logic [$clog2(MFB_REGION_SIZE)-1:0]                      RX_MFB_SOF_POS,
  input  logic [$clog2(MFB_REGION_SIZE*MFB_BLOCK_SIZE)-1:0]       RX_MFB_EOF_POS,
  input  logic                                                    RX_MFB_SOF,
  input  logic                                                    RX_MFB_EOF,
  input  logic                                                    RX_MFB_SRC_RDY,
  output logic                                                    RX_MFB_DST_RDY,
  input  logic [15:0]                                             RX_MVB_DATA,
  input  logic                                                    RX_MVB_BYPASS,
  input  logic                                                    RX_MVB_VLD,
  input  logic                                                    RX_MVB_SRC_RDY,
  output logic                                                    RX_MVB_DST_RDY,
  output logic [MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH-1:0] TX_MFB_DATA,
  output logic [MFB_META_WIDTH-1:0]                               TX_MFB_META,
  output logic [$clog2(MFB_REGION_SIZE)-1:0]                      TX_MFB_SOF_POS,
  output logic [$clog2(MFB_REGION_SIZE*MFB_BLOCK_SIZE)-1:0]       TX_MFB_EOF_POS,
  output logic                                                    TX_MFB_SOF,
  output logic                                                    TX_MFB_EOF,
  output logic                                                    TX_MFB_SRC_RDY,
  input  logic                                                    TX_MFB_DST_RDY
);
  localparam int WB     = MFB_REGION_SIZE * MFB_BLOCK_SIZE;
  localparam int DW     = WB * MFB_ITEM_WIDTH;
  localparam int LANE_W = $clog2(WB);
  localparam int POS_W  = (OFFSET_WIDTH > LANE_W ? OFFSET_WIDTH : LANE_W) + 1;
  localparam int TW_W   = POS_W - LANE_W;
  typedef enum logic {IDLE, PKT} state_t;
  state_t              r_state, w_state_nxt;
  logic [15:0]         r_csum;
  logic                r_bypass;
  logic [TW_W-1:0]     r_tgt_word, r_word_cnt;
  logic [LANE_W-1:0]   r_tgt_lane;
  logic [DW-1:0]       r_tx_data;
  logic [MFB_META_WIDTH-1:0] r_tx_meta;
  logic [$clog2(MFB_REGION_SIZE)-1:0] r_tx_sof_pos;
  logic [LANE_W-1:0]   r_tx_eof_pos;
  logic                r_tx_sof, r_tx_eof, r_tx_src_rdy;
  logic                w_free, w_mvb_ok, w_acc, w_b_ends, w_a_wr, w_b_wr, w_unused;
  logic [POS_W-1:0]    w_pos;
  logic [LANE_W-1:0]   w_b_lane;
  logic [DW-1:0]       w_data;
  assign w_unused       = RX_MFB_OFFSET[0] ^ (DEVICE == "AGILEX");
  assign w_free         = ~r_tx_src_rdy | TX_MFB_DST_RDY;
  assign w_mvb_ok       = RX_MVB_SRC_RDY & RX_MVB_VLD;
  assign RX_MFB_DST_RDY = ~RESET & w_free & (~RX_MFB_SOF | w_mvb_ok);
  assign w_acc          = RX_MFB_SRC_RDY & RX_MFB_DST_RDY;
  assign RX_MVB_DST_RDY = w_acc & RX_MFB_SOF;
  assign w_pos    = POS_W'(RX_MFB_SOF_POS) * POS_W'(MFB_BLOCK_SIZE)
                  + POS_W'({RX_MFB_OFFSET[OFFSET_WIDTH-1:1], 1'b0});
  assign w_b_lane = w_pos[LANE_W-1:0];
  // In IDLE an EOF in the SOF word closes the new packet; in PKT it closes the held one
  assign w_b_ends = RX_MFB_EOF & (r_state == IDLE);
  assign w_a_wr   = (r_state == PKT) & ~r_bypass & (r_word_cnt == r_tgt_word)
                  & (~RX_MFB_EOF | ({r_tgt_lane[LANE_W-1:1], 1'b1} <= RX_MFB_EOF_POS));
  assign w_b_wr   = RX_MFB_SOF & ~RX_MVB_BYPASS & (w_pos[POS_W-1:LANE_W] == '0)
                  & (~w_b_ends | ({w_b_lane[LANE_W-1:1], 1'b1} <= RX_MFB_EOF_POS));
  always_comb begin
    w_data = RX_MFB_DATA;
    for (int l = 0; l < WB; l++) begin
      if (w_a_wr && LANE_W'(l) == r_tgt_lane)
        w_data[l*MFB_ITEM_WIDTH +: MFB_ITEM_WIDTH] = MFB_ITEM_WIDTH'(r_csum[15:8]);
      if (w_a_wr && LANE_W'(l) == {r_tgt_lane[LANE_W-1:1], 1'b1})
        w_data[l*MFB_ITEM_WIDTH +: MFB_ITEM_WIDTH] = MFB_ITEM_WIDTH'(r_csum[7:0]);
      if (w_b_wr && LANE_W'(l) == w_b_lane)
        w_data[l*MFB_ITEM_WIDTH +: MFB_ITEM_WIDTH] = MFB_ITEM_WIDTH'(RX_MVB_DATA[15:8]);
      if (w_b_wr && LANE_W'(l) == {w_b_lane[LANE_W-1:1], 1'b1})
        w_data[l*MFB_ITEM_WIDTH +: MFB_ITEM_WIDTH] = MFB_ITEM_WIDTH'(RX_MVB_DATA[7:0]);
    end
  end
  always_comb begin
    w_state_nxt = !w_acc ? r_state :
                  RX_MFB_SOF ? (w_b_ends ? IDLE : PKT) :
                  RX_MFB_EOF ? IDLE : r_state;
  end
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_csum       <= '0;
      r_bypass     <= 1'b0;
      r_tgt_word   <= '0;
      r_tgt_lane   <= '0;
      r_word_cnt   <= '0;
      r_tx_src_rdy <= 1'b0;
    end else begin
      if (w_acc && RX_MFB_SOF) begin
        r_csum     <= RX_MVB_DATA;
        r_bypass   <= RX_MVB_BYPASS;
        r_tgt_word <= w_pos[POS_W-1:LANE_W];
        r_tgt_lane <= w_b_lane;
        r_word_cnt <= TW_W'(1);
      end else if (w_acc) begin
        r_word_cnt <= r_word_cnt + TW_W'(r_word_cnt != '1);
      end
      if (w_free) r_tx_src_rdy <= w_acc;
    end
  end
  always_ff @(posedge CLK) begin
    if (w_free) begin
      r_tx_data    <= w_data;
      r_tx_meta    <= RX_MFB_META;
      r_tx_sof_pos <= RX_MFB_SOF_POS;
      r_tx_eof_pos <= RX_MFB_EOF_POS;
      r_tx_sof     <= RX_MFB_SOF;
      r_tx_eof     <= RX_MFB_EOF;
    end
  end
  assign TX_MFB_DATA    = r_tx_data;
  assign TX_MFB_META    = r_tx_meta;
  assign TX_MFB_SOF_POS = r_tx_sof_pos;
  assign TX_MFB_EOF_POS = r_tx_eof_pos;
  assign TX_MFB_SOF     = r_tx_sof;
  assign TX_MFB_EOF     = r_tx_eof;
  assign TX_MFB_SRC_RDY = r_tx_src_rdy;
endmodule
